// File: rtl/pipe_reg_chain.sv
// Elastic multi-stage register pipeline with valid/ready handshake, bubble collapsing,
// optional registered-ready skid entry, synchronous flush and occupancy count.
module pipe_reg_chain #(
    parameter int unsigned Width    = 16,
    parameter int unsigned Depth    = 2,
    parameter int unsigned RegReady = 1,
    localparam int unsigned OccW    = $clog2(Depth + 2)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [Width-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [Width-1:0] m_data_o,
    output logic [OccW-1:0]  occupancy_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [Width-1:0] data_q [Depth];
    logic [Width-1:0] data_d [Depth];
    logic [Depth-1:0] ld;
    logic             skid_valid_q;
    logic [Width-1:0] skid_data_q;
    logic             xfer_in, xfer_out;
    logic             src_valid;
    logic [Width-1:0] src_data;
    logic [OccW-1:0]  occ_q, occ_d;

    // A stage may load when any stage at or downstream of it is empty, or the sink is taking a
    // beat; written without a self-referencing chain so the cone stays flat.
    always_comb begin
        ld = '0;
        for (int k = 0; k < Depth; k++) begin
            ld[k] = m_ready_i;
            for (int j = k; j < Depth; j++) begin
                if (!valid_q[j]) begin
                    ld[k] = 1'b1;
                end
            end
        end
    end

    assign xfer_in   = s_valid_i & s_ready_o;
    assign xfer_out  = m_valid_o & m_ready_i;
    assign m_valid_o = valid_q[Depth-1];
    assign m_data_o  = data_q[Depth-1];

    assign src_valid = skid_valid_q | xfer_in;
    assign src_data  = skid_valid_q ? skid_data_q : s_data_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ld[0]) begin
            valid_d[0] = src_valid;
            if (src_valid) begin
                data_d[0] = src_data;
            end
        end
        for (int k = 1; k < Depth; k++) begin
            if (ld[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int k = 0; k < Depth; k++) begin
                data_q[k] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    if (RegReady != 0) begin : g_skid
        logic             skid_valid_d;
        logic [Width-1:0] skid_data_d;

        // Skid only fills when stage 0 cannot load; it is empty again whenever stage 0 loads.
        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (skid_valid_q) begin
                if (ld[0]) begin
                    skid_valid_d = 1'b0;
                end
            end else if (xfer_in && !ld[0]) begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_data_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else if (flush_i) begin
                skid_valid_q <= 1'b0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end

        assign s_ready_o = !skid_valid_q && !flush_i;
    end else begin : g_no_skid
        assign skid_valid_q = 1'b0;
        assign skid_data_q  = '0;
        assign s_ready_o    = ld[0] && !flush_i;
    end

    always_comb begin
        occ_d = occ_q;
        unique case ({xfer_in, xfer_out})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomised checks of two pipe_reg_chain configurations sharing one stimulus:
// index 0 is Depth=3/RegReady=0, index 1 is Depth=2/RegReady=1.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rst, flush, s_valid, m_ready;
    logic [15:0] s_data;
    logic        s_ready_a, m_valid_a, s_ready_b, m_valid_b;
    logic [15:0] m_data_a, m_data_b;
    logic [2:0]  occ_a;
    logic [1:0]  occ_b;

    always #5 clk = ~clk;

    pipe_reg_chain #(.Width(16), .Depth(3), .RegReady(0)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(s_valid), .s_ready_o(s_ready_a),
        .s_data_i(s_data), .m_valid_o(m_valid_a), .m_ready_i(m_ready), .m_data_o(m_data_a),
        .occupancy_o(occ_a)
    );

    pipe_reg_chain #(.Width(16), .Depth(2), .RegReady(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(s_valid), .s_ready_o(s_ready_b),
        .s_data_i(s_data), .m_valid_o(m_valid_b), .m_ready_i(m_ready), .m_data_o(m_data_b),
        .occupancy_o(occ_b)
    );

    logic [31:0] sr [2];
    logic [31:0] mv [2];
    logic [31:0] md [2];
    logic [31:0] oc [2];
    assign sr[0] = 32'(s_ready_a);
    assign sr[1] = 32'(s_ready_b);
    assign mv[0] = 32'(m_valid_a);
    assign mv[1] = 32'(m_valid_b);
    assign md[0] = 32'(m_data_a);
    assign md[1] = 32'(m_data_b);
    assign oc[0] = 32'(occ_a);
    assign oc[1] = 32'(occ_b);

    int          depth_k [2] = '{3, 2};
    int          regr_k  [2] = '{0, 1};
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q [2][$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, ev, ed, eo, er, outs, ins;
        logic push [2];
        logic pop  [2];
        logic [15:0] ctr;

        do_reset();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("reset_valid%0d", k), mv[k], 0);
            check_eq($sformatf("reset_data%0d", k), md[k], 0);
            check_eq($sformatf("reset_occ%0d", k), oc[k], 0);
            check_eq($sformatf("reset_ready%0d", k), sr[k], 1);
        end

        // Full-rate stream of 0x0001..0x0010.
        for (int i = 0; i < 20; i++) begin
            s_valid = (i < 16); s_data = 16'(i + 1); m_ready = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) check_eq($sformatf("stream_ready%0d", k), sr[k], 1);
            step();
            for (int k = 0; k < 2; k++) begin
                d    = depth_k[k];
                ev   = (i >= d - 1 && i <= d + 14) ? 1 : 0;
                ins  = (i + 1 < 16) ? i + 1 : 16;
                outs = (i - d + 1 < 0) ? 0 : ((i - d + 1 > 16) ? 16 : i - d + 1);
                check_eq($sformatf("stream_valid%0d_c%0d", k, i), mv[k], 32'(ev));
                if (ev != 0) check_eq($sformatf("stream_data%0d_c%0d", k, i), md[k], 32'(i - d + 2));
                check_eq($sformatf("stream_occ%0d_c%0d", k, i), oc[k], 32'(ins - outs));
            end
        end

        // Back-pressure fill: capacity is 3 for both configurations.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_data = 16'(16'hA0 + i); m_ready = 1'b0;
            #1;
            for (int k = 0; k < 2; k++)
                check_eq($sformatf("stall_ready%0d_c%0d", k, i), sr[k], 32'(i < 3 ? 1 : 0));
            step();
            for (int k = 0; k < 2; k++) begin
                ev = (i >= depth_k[k] - 1) ? 1 : 0;
                check_eq($sformatf("stall_occ%0d_c%0d", k, i), oc[k], 32'(i + 1 < 3 ? i + 1 : 3));
                check_eq($sformatf("stall_valid%0d_c%0d", k, i), mv[k], 32'(ev));
                if (ev != 0) check_eq($sformatf("stall_hold%0d_c%0d", k, i), md[k], 32'h00A0);
            end
        end
        s_valid = 1'b0; m_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 2; k++) begin
                er = (regr_k[k] != 0 && j == 0) ? 0 : 1;
                check_eq($sformatf("release_ready%0d_c%0d", k, j), sr[k], 32'(er));
                check_eq($sformatf("release_valid%0d_c%0d", k, j), mv[k], 32'(j < 3 ? 1 : 0));
                if (j < 3) check_eq($sformatf("release_data%0d_c%0d", k, j), md[k], 32'(16'hA0 + j));
            end
            step();
        end

        // Bubbles collapse while stalled, then leave back-to-back.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s_valid = (i == 0 || i == 3); s_data = (i == 0) ? 16'h00B1 : 16'h00B2; m_ready = 1'b0;
            step();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("bubble_occ%0d", k), oc[k], 2);
            check_eq($sformatf("bubble_valid%0d", k), mv[k], 1);
            check_eq($sformatf("bubble_data%0d", k), md[k], 32'h00B1);
        end
        m_ready = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("bubble_out_valid%0d_c%0d", k, j), mv[k], 32'(j < 2 ? 1 : 0));
                if (j < 2) check_eq($sformatf("bubble_out_data%0d_c%0d", k, j), md[k], 32'(16'hB1 + j));
            end
            step();
        end

        // Flush of a full pipeline with a beat offered in the flush cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 16'(16'hC0 + i); m_ready = 1'b0;
            step();
        end
        flush = 1'b1; s_data = 16'h00CF;
        #1;
        for (int k = 0; k < 2; k++) check_eq($sformatf("flush_ready%0d", k), sr[k], 0);
        step();
        flush = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("flush_valid%0d", k), mv[k], 0);
            check_eq($sformatf("flush_occ%0d", k), oc[k], 0);
        end
        s_valid = 1'b1; s_data = 16'h00D1; m_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check_eq($sformatf("postflush_ready%0d", k), sr[k], 1);
        step();
        s_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 2; k++) begin
                ev = (j == depth_k[k] - 1) ? 1 : 0;
                check_eq($sformatf("postflush_valid%0d_c%0d", k, j), mv[k], 32'(ev));
                if (ev != 0) check_eq($sformatf("postflush_data%0d", k), md[k], 32'h00D1);
            end
            step();
        end

        // Reset while two beats are held.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 16'(16'hE1 + i); m_ready = 1'b0;
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("midrst_valid%0d", k), mv[k], 0);
            check_eq($sformatf("midrst_data%0d", k), md[k], 0);
            check_eq($sformatf("midrst_occ%0d", k), oc[k], 0);
            check_eq($sformatf("midrst_ready%0d", k), sr[k], 1);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            for (int k = 0; k < 2; k++) check_eq($sformatf("midrst_quiet%0d_c%0d", k, j), mv[k], 0);
        end

        // Random handshakes against a FIFO model of each configuration.
        do_reset();
        ctr = 16'h1000;
        for (int c = 0; c < 3000; c++) begin
            s_valid = 1'($urandom_range(0, 1)); m_ready = 1'($urandom_range(0, 1));
            s_data = ctr; ctr = ctr + 16'd1;
            #1;
            for (int k = 0; k < 2; k++) begin
                eo = q[k].size();
                er = (regr_k[k] != 0) ? ((eo <= depth_k[k]) ? 1 : 0)
                                      : ((eo < depth_k[k] || m_ready) ? 1 : 0);
                check_eq($sformatf("rand_ready%0d_c%0d", k, c), sr[k], 32'(er));
                push[k] = s_valid && (er != 0);
                pop[k]  = 1'b0;
                if (mv[k][0]) begin
                    check_eq($sformatf("rand_nonempty%0d_c%0d", k, c), 32'(eo > 0 ? 1 : 0), 1);
                    if (eo > 0) begin
                        ed = int'(q[k][0]);
                        check_eq($sformatf("rand_data%0d_c%0d", k, c), md[k], 32'(ed));
                        pop[k] = m_ready;
                    end
                end
            end
            step();
            for (int k = 0; k < 2; k++) begin
                if (pop[k]) void'(q[k].pop_front());
                if (push[k]) q[k].push_back(s_data);
                check_eq($sformatf("rand_occ%0d_c%0d", k, c), oc[k], 32'(q[k].size()));
            end
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                pop[k] = 1'b0;
                if (mv[k][0] && q[k].size() > 0) begin
                    ed = int'(q[k][0]);
                    check_eq($sformatf("drain_data%0d_c%0d", k, c), md[k], 32'(ed));
                    pop[k] = 1'b1;
                end
            end
            step();
            for (int k = 0; k < 2; k++) if (pop[k]) void'(q[k].pop_front());
        end
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("drain_left%0d", k), 32'(q[k].size()), 0);
            check_eq($sformatf("drain_occ%0d", k), oc[k], 0);
            check_eq($sformatf("drain_valid%0d", k), mv[k], 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised multi-stage register pipeline with a valid/ready handshake, bubble collapsing, optional registered-ready skid stage, synchronous flush and occupancy count. Generalises the single enabled reset register to a Depth-stage elastic delay line. Used between processing stages of the codec datapath (DWT, quantiser, coefficient packer) to cut timing paths without losing throughput under back-pressure.

## Interface
- Width, 16, data bits per beat (>=1)
- Depth, 2, number of pipeline stages (>=1)
- RegReady, 1, 1 = add one input skid entry so s_ready_o is driven directly from a flop; 0 = s_ready_o combinational from downstream
- OccW, $clog2(Depth+2), occupancy counter width (derived, not overridden)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- flush_i  input  1  synchronous clear of all held beats
- s_valid_i  input  1  upstream beat valid
- s_ready_o  output  1  block accepts upstream beat this cycle
- s_data_i  input  Width  upstream data
- m_valid_o  output  1  output beat valid (stage Depth-1)
- m_ready_i  input  1  downstream accepts beat
- m_data_o  output  Width  output data (stage Depth-1)
- occupancy_o  output  OccW  beats currently held (stages + skid)

## Operation
- State: per stage k in 0..Depth-1 a valid_q[k] and data_q[k]; if RegReady=1 also skid_valid_q, skid_data_q.
- Transfer in = s_valid_i & s_ready_o; transfer out = m_valid_o & m_ready_i.
- Stage advance: load_k = !valid_q[k] | adv_{k+1}, with adv_Depth = m_ready_i. A stage that loads takes stage k-1's beat (valid follows); a stage whose beat moves on and gets nothing becomes invalid. Bubbles collapse: an empty stage always loads, regardless of downstream stall.
- Stage 0 source: skid entry if skid_valid_q, else s_data_i/s_valid_i transfer.
- RegReady=0: s_ready_o = load_0 (combinational); no skid.
- RegReady=1: s_ready_o = !skid_valid_q. Accepted beat goes to stage 0 if load_0 and skid empty, else into skid. Skid drains into stage 0 whenever load_0; a simultaneous new beat goes into the freed skid only if skid was not valid at cycle start (it cannot: ready low), so skid never overflows.
- Ordering strictly FIFO; no beat duplicated or dropped except by flush/reset.
- Capacity = Depth + RegReady beats.
- occupancy_o: registered counter, +1 on transfer in, -1 on transfer out, both = unchanged; always equals popcount of valid flops.
- flush_i: next cycle all valid flops and occupancy = 0; s_ready_o forced 0 during the flush cycle (no beat accepted); m_valid_o not forced low in that cycle, but any transfer out is ignored for counting (count goes to 0). Data flops keep values.
- rst_i: highest priority; overrides flush and handshakes.

## Timing
- Reset values: all valid flops 0, all data flops 0, occupancy_o 0, m_valid_o 0, m_data_o 0; s_ready_o 1 in the cycle after reset releases (0 while rst_i high for RegReady=1 is not required; it must be 1 after).
- Latency empty-to-output: beat accepted at edge t shows m_valid_o after edge t+Depth-1 (i.e. Depth cycles of register delay), identical for RegReady=0/1 when skid empty.
- Throughput: 1 beat/cycle with m_ready_i held high, any Depth, both RegReady values.
- Stall: m_ready_i low -> pipeline fills; s_ready_o drops after Depth+RegReady accepted beats. Re-assert m_ready_i -> s_ready_o high next cycle (RegReady=1) or same cycle (RegReady=0).
- m_data_o stable while m_valid_o & !m_ready_i.
- Reset mid-stream: held beats lost, no spurious m_valid_o after reset.

## Test plan
- Reset then stream 0x0001..0x0010 with m_ready_i=1, Depth=3 -> first m_valid_o 3 cycles after first accept, all 16 values in order, no gaps, occupancy_o steady 3.
- Depth=2, RegReady=1, m_ready_i=0, s_valid_i=1 -> exactly 3 beats accepted, s_ready_o=0 thereafter, occupancy_o=3, m_data_o=first beat held.
- Inject bubbles (s_valid_i 1,0,0,1) with m_ready_i=0 -> beats collapse to adjacent stages, occupancy_o=2, release yields both in order back-to-back.
- Random s_valid_i/m_ready_i (50%) 10k beats, both RegReady values -> scoreboard exact order match, occupancy_o equals model count every cycle.
- Full pipeline, flush_i for 1 cycle with s_valid_i=1 -> that beat not accepted, next cycle m_valid_o=0, occupancy_o=0, subsequent beat exits after Depth cycles.
- rst_i asserted with 2 beats held and m_ready_i=1 -> all outputs at reset values next cycle, no held beat ever appears.
